fifo_pkt_reader: RTL and testbench

Read-side consumer for the synchronous FWFT FIFO: pops header-delimited packets from the FIFO read port and presents them downstream as a valid/ready word stream with start/end-of-packet markers. It sits between each port FIFO and the downstream arbiter/cache-write logic. It converts the FIFO's `empty`/`rd_en` interface into a back-pressurable stream at full throughput (one word per cycle).

---
 rtl/mpc_pkt_pkg.sv | 8 +
 rtl/fifo_pkt_reader.sv | 113 +++++++++++
 tb/tb_fifo_pkt_reader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mpc_pkt_pkg.sv
// Shared types and constants for the packet reader on the port-FIFO read side.
package mpc_pkt_pkg;
  typedef enum logic {S_HDR, S_PAY} pkt_rd_state_t;

  localparam int unsigned HDR_LEN_LSB   = 0;
  localparam int unsigned PKT_LEN_WIDTH = 4;
  typedef logic [PKT_LEN_WIDTH-1:0] pkt_len_t;
endpackage

// File: rtl/fifo_pkt_reader.sv
// Pops header-delimited packets from an FWFT FIFO and re-presents them as a
// valid/ready stream with sop/eop markers, one word per cycle.
module fifo_pkt_reader
  import mpc_pkt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned LEN_WIDTH     = 4,
  parameter int unsigned PKT_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    fifo_dout,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic                     in_pkt,
  output logic [PKT_CNT_WIDTH-1:0] pkt_cnt
);

  pkt_rd_state_t            state_q, state_d;
  logic [LEN_WIDTH-1:0]     remain_q, remain_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     sop_q, sop_d;
  logic                     eop_q, eop_d;
  logic [PKT_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                     pop;
  logic                     accept;
  logic [LEN_WIDTH-1:0]     hdr_len;

  assign hdr_len = fifo_dout[HDR_LEN_LSB +: LEN_WIDTH];
  assign accept  = valid_q & out_ready;
  // Reset gating keeps the FIFO untouched while both blocks are held in reset.
  assign pop     = rst_n & ~fifo_empty & (~valid_q | out_ready);

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    data_d   = data_q;
    valid_d  = valid_q;
    sop_d    = sop_q;
    eop_d    = eop_q;
    cnt_d    = cnt_q;

    if (accept && eop_q) cnt_d = cnt_q + 1'b1;

    if (pop) begin
      data_d  = fifo_dout;
      valid_d = 1'b1;
      unique case (state_q)
        S_HDR: begin
          sop_d = 1'b1;
          if (hdr_len == '0) begin
            eop_d = 1'b1;
          end else begin
            eop_d    = 1'b0;
            remain_d = hdr_len;
            state_d  = S_PAY;
          end
        end
        S_PAY: begin
          sop_d    = 1'b0;
          remain_d = remain_q - 1'b1;
          if (remain_q == LEN_WIDTH'(1)) begin
            eop_d   = 1'b1;
            state_d = S_HDR;
          end else begin
            eop_d = 1'b0;
          end
        end
        default: state_d = S_HDR;
      endcase
    end else if (accept) begin
      valid_d = 1'b0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_HDR;
      remain_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fifo_rd_en = pop;
  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign out_sop    = sop_q;
  assign out_eop    = eop_q;
  assign in_pkt     = (state_q == S_PAY);
  assign pkt_cnt    = cnt_q;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench: queue-based FIFO and stream model, directed scenarios then random traffic.
module tb_fifo_pkt_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic        out_ready = 1'b0;
  logic        fifo_rd_en, out_valid, out_sop, out_eop, in_pkt;
  logic [7:0]  out_data;
  logic [15:0] pkt_cnt;
  logic        rd2, v2, s2, e2, ip2;
  logic [7:0]  d2;
  logic [1:0]  pkt_cnt2;

  always #5 clk = ~clk;

  fifo_pkt_reader #(.DATA_WIDTH(8), .LEN_WIDTH(4), .PKT_CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
    .in_pkt(in_pkt), .pkt_cnt(pkt_cnt));

  fifo_pkt_reader #(.DATA_WIDTH(8), .LEN_WIDTH(4), .PKT_CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd2), .out_data(d2), .out_valid(v2),
    .out_ready(out_ready), .out_sop(s2), .out_eop(e2),
    .in_pkt(ip2), .pkt_cnt(pkt_cnt2));

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] q[$];    // words currently held in the FIFO
  logic [7:0] src[$];  // words waiting to be written into the FIFO
  logic [9:0] log_q[$]; // accepted words as {data, sop, eop}
  int         cnt2_seq[$];

  logic       m_valid, m_sop, m_eop;
  logic [7:0] m_data;
  int         m_rem, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_valid = 0; m_sop = 0; m_eop = 0; m_data = '0; m_rem = 0; m_cnt = 0;
    q.delete(); src.delete(); log_q.delete();
  endtask

  task automatic compare_outputs();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("out_sop",   32'(out_sop),   32'(m_sop));
    chk("out_eop",   32'(out_eop),   32'(m_eop));
    chk("in_pkt",    32'(in_pkt),    32'(m_rem != 0));
    chk("pkt_cnt",   32'(pkt_cnt),   32'(m_cnt % 65536));
    chk("pkt_cnt2",  32'(pkt_cnt2),  32'(m_cnt % 4));
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic cyc(input bit rdy, input int feed_pct);
    logic       exp_rd, acc;
    logic [7:0] w;
    int         prev2;
    out_ready = rdy;
    if (src.size() > 0 && $urandom_range(99) < feed_pct) q.push_back(src.pop_front());
    fifo_empty = (q.size() == 0);
    fifo_dout  = fifo_empty ? 8'($urandom) : q[0];
    #1;
    exp_rd = !fifo_empty && (!m_valid || rdy);
    chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    acc = m_valid && rdy;
    if (acc) begin
      log_q.push_back({m_data, m_sop, m_eop});
      if (m_eop) m_cnt++;
    end
    if (exp_rd) begin
      w = q.pop_front();
      m_data = w; m_valid = 1;
      if (m_rem == 0) begin
        m_sop = 1; m_rem = int'(w[3:0]); m_eop = (m_rem == 0);
      end else begin
        m_sop = 0; m_rem--; m_eop = (m_rem == 0);
      end
    end else if (acc) begin
      m_valid = 0; m_sop = 0; m_eop = 0;
    end
    prev2 = int'(pkt_cnt2);
    @(posedge clk); #1;
    compare_outputs();
    if (int'(pkt_cnt2) != prev2) cnt2_seq.push_back(int'(pkt_cnt2));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    fifo_empty = 1'b0; fifo_dout = 8'h05;  // non-empty FIFO must still not be popped
    #1;
    chk("rst rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst valid", 32'(out_valid), 32'd0);
    chk("rst data",  32'(out_data), 32'd0);
    chk("rst sop_eop", 32'({out_sop, out_eop, in_pkt}), 32'd0);
    chk("rst cnt",   32'(pkt_cnt), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    fifo_empty = 1'b1;
  endtask

  task automatic chk_log(input string name, input int idx, input logic [9:0] exp);
    chk(name, (idx < log_q.size()) ? 32'(log_q[idx]) : 32'h3ff_ffff, 32'(exp));
  endtask

  initial begin
    model_clear();
    @(posedge clk); #1;
    do_reset();

    // Basic 2-payload packet.
    src = '{8'h02, 8'hA1, 8'hA2};
    repeat (6) cyc(1, 100);
    chk_log("t1 w0", 0, {8'h02, 1'b1, 1'b0});
    chk_log("t1 w1", 1, {8'hA1, 1'b0, 1'b0});
    chk_log("t1 w2", 2, {8'hA2, 1'b0, 1'b1});
    chk("t1 cnt", 32'(pkt_cnt), 32'd1);

    // Header-only packet immediately followed by a 3-payload packet.
    log_q.delete();
    src = '{8'h00, 8'h03, 8'hB1, 8'hB2, 8'hB3};
    repeat (8) cyc(1, 100);
    chk_log("t2 hdr-only", 0, {8'h00, 1'b1, 1'b1});
    chk_log("t2 next hdr", 1, {8'h03, 1'b1, 1'b0});
    chk_log("t2 last",     4, {8'hB3, 1'b0, 1'b1});
    chk("t2 cnt", 32'(pkt_cnt), 32'd3);

    // Stall on the second word.
    log_q.delete();
    src = '{8'h03, 8'hB1, 8'hB2, 8'hB3};
    cyc(1, 100); cyc(1, 100);
    repeat (3) begin
      cyc(0, 100);
      chk("t3 hold", 32'(out_data), 32'hB1);
    end
    repeat (6) cyc(1, 100);
    chk_log("t3 w1", 1, {8'hB1, 1'b0, 1'b0});
    chk_log("t3 w3", 3, {8'hB3, 1'b0, 1'b1});
    chk("t3 cnt", 32'(pkt_cnt), 32'd4);

    // FIFO runs dry mid-packet.
    log_q.delete();
    src = '{8'h02, 8'hC1};
    repeat (3) cyc(1, 100);
    repeat (5) begin
      cyc(1, 0);
      chk("t4 in_pkt", 32'(in_pkt), 32'd1);
    end
    src = '{8'hC2};
    repeat (3) cyc(1, 100);
    chk_log("t4 eop", 2, {8'hC2, 1'b0, 1'b1});

    // Reset in the middle of a packet, then a fresh packet.
    src = '{8'h03, 8'hE1, 8'hE2};
    repeat (2) cyc(0, 100);
    cyc(1, 100);
    do_reset();
    src = '{8'h01, 8'hD1};
    repeat (4) cyc(1, 100);
    chk_log("t5 hdr", 0, {8'h01, 1'b1, 1'b0});
    chk_log("t5 pay", 1, {8'hD1, 1'b0, 1'b1});
    chk("t5 cnt", 32'(pkt_cnt), 32'd1);

    // 2-bit counter wrap on header-only packets.
    do_reset();
    cnt2_seq.delete();
    repeat (5) src.push_back(8'h00);
    repeat (8) cyc(1, 100);
    chk("t6 n", 32'(cnt2_seq.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      int exp_v[5] = '{1, 2, 3, 0, 1};
      chk("t6 seq", (i < cnt2_seq.size()) ? 32'(cnt2_seq[i]) : 32'hffff_ffff, 32'(exp_v[i]));
    end

    // Random traffic.
    for (int seg = 0; seg < 20; seg++) begin
      int feed = $urandom_range(40, 100);
      int rdy_pct = $urandom_range(30, 100);
      for (int c = 0; c < 100; c++) begin
        if (src.size() == 0) begin
          int n = $urandom_range(0, 15);
          src.push_back({4'($urandom), 4'(n)});
          for (int k = 0; k < n; k++) src.push_back(8'($urandom));
        end
        cyc($urandom_range(99) < rdy_pct, feed);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
